ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction cache and directly upstream of decode.
- Owns the PC and drives the cache's CPU-side request/address.
- Captures returned instructions into a one-entry output buffer with a valid/ready handshake to decode.
- Applies branch/jump redirects from execute, discarding any in-flight wrong-path fetch.
- Allows one outstanding cache request at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_WIDTH, 32 (from _riscv_defines), PC/address width.
INST_WIDTH, 32, instruction width.

Ports:
clk  input  1  clock; everything is sampled on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
cpu_if  modport cpu_cache_if.cpu  -  cache CPU side: drives req and addr[ADDR_WIDTH-1:0]; receives ready and rdata[31:0].
redirect_valid  input  1  one-cycle pulse: the PC must change to redirect_pc.
redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
inst_valid  output  1  output buffer holds an instruction.
inst_ready  input  1  decode accepts the instruction this cycle.
inst  output  INST_WIDTH  buffered instruction.
inst_pc  output  ADDR_WIDTH  PC of the buffered instruction.

Behaviour:
- Reset, asynchronous on rst_n low, in any state including mid-request:
  - state=IDLE, pc=RESET_PC, cpu_if.req=0, cpu_if.addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0.
  - kill=0, kill_pc=0.
- Cache contract:
  - cpu_if.addr is always the pc register.
  - pc and cpu_if.req must not change while a request is open (REQ state) until cpu_if.ready.
  - The cache takes at least 2 cycles from the first req cycle to ready.
  - ready is a 1-cycle pulse.
  - rdata is valid only in the ready cycle.
- States:
  - IDLE: req=0.
    - Goes to REQ when (!inst_valid || inst_ready) && !redirect_valid.
    - When redirect_valid is high in IDLE: pc<=redirect_pc&~3, and the state stays IDLE for that cycle. The next cycle re-evaluates.
  - REQ: req=1, held continuously until ready.
    - On ready with kill=0 and no redirect_valid this cycle: inst<=rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (wraps modulo 2^ADDR_WIDTH), then go to IDLE.
    - On ready with kill=1: drop rdata, pc<=kill_pc, kill<=0, and stay in REQ (a new request starts the next cycle).
    - On ready with redirect_valid the same cycle: drop rdata, pc<=redirect_pc&~3, kill<=0, and stay in REQ. The redirect overrides kill_pc.
    - redirect_valid in REQ without ready: kill<=1, kill_pc<=redirect_pc&~3. A later redirect before ready overwrites kill_pc.
- Output buffer:
  - When inst_valid && inst_ready: inst_valid<=0, unless it is reloaded on the same edge. That cannot happen by construction: REQ is entered only when the buffer is free or draining.
  - redirect_valid clears inst_valid on the same edge. Flush has priority over drain.
  - inst and inst_pc hold their value while inst_valid && !inst_ready.
- Latency:
  - Redirect to a new fetch: the new address appears on cpu_if.addr the edge after redirect (IDLE) or after the in-flight ready (REQ).
  - Throughput: with a 2-cycle hit and inst_ready held high, one instruction every 3 cycles. There is no prefetch.

Decomposition:
- In _riscv_defines:
  - the ifetch_state_t enum {IDLE, REQ} (logic [0:0]);
  - the RESET_PC default;
  - the INST_WIDTH constant.
- Reuse the existing ADDR_WIDTH.
- One sub-module, if_inst_buffer: the one-entry valid/ready register.
  - Inputs: load, flush, data and pc.
  - Outputs: inst_valid/inst/inst_pc and a "free" signal (!valid || ready) back to the FSM.
- The FSM, pc and kill logic stay in ifetch_unit.

Test Plan:
- Reset, then a cache model hitting in 2 cycles with inst_ready=1:
  - first request has addr=0x0000_0000;
  - inst_pc sequence is 0x0, 0x4, 0x8;
  - inst equals the model's word at each address;
  - req never drops while waiting.
- Decode back-pressure: hold inst_ready=0 after the first instruction.
  - inst_valid stays 1, inst/inst_pc are stable, req stays 0 with no new request.
  - Release inst_ready: the next request at 0x4 starts the following cycle.
- Redirect to 0x0000_1002 during an open request with an 8-cycle miss:
  - addr stays at the old pc until ready;
  - rdata is dropped, with no inst_valid pulse;
  - the next request has addr=0x0000_1000.
- Redirect coincident with ready, and two redirects (0x100, then 0x200) inside one miss:
  - ready-cycle data is discarded;
  - the next fetch address is the latest target (0x200).
- Redirect while inst_valid=1 and inst_ready=0: inst_valid drops the next edge and the next fetch uses the redirect target.
- Assert rst_n=0 mid-miss:
  - req=0, inst_valid=0 and pc=RESET_PC immediately, asynchronously;
  - after release, fetch restarts at RESET_PC;
  - a late ready from the cache while in IDLE is ignored.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC default and FSM encoding.
package ifetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } ifetch_state_t;

  // Instructions are word aligned; the two low address bits never reach the cache.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_cache_if.sv
// CPU-side port of the instruction cache: one open request at a time,
// ready is a single-cycle pulse and rdata is only meaningful alongside it.
interface cpu_cache_if;
  import ifetch_unit_pkg::*;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic [31:0]           rdata;

  modport cpu   (output req, output addr, input  ready, input  rdata);
  modport cache (input  req, input  addr, output ready, output rdata);

endinterface

// File: rtl/ifetch_unit_buffer.sv
// One-entry instruction holding register between fetch and decode.
module if_inst_buffer
  import ifetch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [INST_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  ready,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  free
);

  // Fetch may start a request when the entry is empty or is being drained now.
  assign free = !valid || ready;

  // Flush beats drain; load never coincides with flush since the FSM gates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      inst    <= data;
      inst_pc <= pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one cache request at a time and
// discards wrong-path data after a redirect.
//
// state | meaning
// IDLE  | no request open; wait for buffer space, apply redirects directly to pc
// REQ   | request open at pc; pc/req frozen until cache ready
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_cache_if.cpu              cpu_if,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  ifetch_state_t         state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] kill_pc;
  logic [ADDR_WIDTH-1:0] target;
  logic                  kill;
  logic                  req_q;
  logic                  buf_free;
  logic                  buf_load;

  assign target      = align_pc(redirect_pc);
  assign cpu_if.addr = pc;
  assign cpu_if.req  = req_q;

  // Only a clean return (no pending kill, no redirect this cycle) reaches decode.
  assign buf_load = (state == REQ) && cpu_if.ready && !kill && !redirect_valid;

  // Fetch sequencing; a redirect during an open request is parked in kill_pc
  // because the cache contract forbids changing the address before ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      req_q   <= 1'b0;
      kill    <= 1'b0;
      kill_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= target;
          end else if (buf_free) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (cpu_if.ready) begin
            if (redirect_valid) begin
              pc   <= target;
              kill <= 1'b0;
            end else if (kill) begin
              pc   <= kill_pc;
              kill <= 1'b0;
            end else begin
              pc    <= pc + ADDR_WIDTH'(4);
              state <= IDLE;
              req_q <= 1'b0;
            end
          end else if (redirect_valid) begin
            kill    <= 1'b1;
            kill_pc <= target;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_inst_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load),
    .flush   (redirect_valid),
    .data    (cpu_if.rdata),
    .pc      (pc),
    .ready   (inst_ready),
    .valid   (inst_valid),
    .inst    (inst),
    .inst_pc (inst_pc),
    .free    (buf_free)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cache model with programmable latency, a
// transaction-level fetch model checked every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  cpu_cache_if cif ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_if         (cif),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cache_lat = 2;
  bit late_ready = 1'b0;
  bit c_active = 1'b0;
  int c_cnt = 0;
  int c_lat = 2;

  // Fetch model: "fetching" = a request is outstanding at f_pc; "stale" = its data is wrong-path.
  bit          f_fetching;
  logic [31:0] f_pc;
  bit          f_stale;
  logic [31:0] f_next;
  bit          o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fresh_req(output bit ok);
    int n;
    n = 0;
    while (cif.req && n < 40) begin tick(); n++; end
    while (!cif.req && n < 40) begin tick(); n++; end
    ok = cif.req;
    chk("wait_req", {31'b0, ok}, 32'd1);
  endtask

  // Per-cycle: compare DUT with model, act as the cache, then advance the model.
  always @(negedge clk) begin
    logic [31:0] aligned;
    bit          room;
    if (!rst_n) begin
      f_fetching = 0; f_pc = 32'h0; f_stale = 0; f_next = 32'h0;
      o_valid = 0; o_inst = 32'h0; o_pc = 32'h0;
      c_active = 0;
      cif.ready = 1'b0;
      cif.rdata = 32'h0;
    end else begin
      chk("req", {31'b0, cif.req}, {31'b0, f_fetching});
      chk("addr", cif.addr, f_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, o_valid});
      chk("inst", inst, o_inst);
      chk("inst_pc", inst_pc, o_pc);

      if (late_ready) begin
        cif.ready = 1'b1;
        cif.rdata = 32'hDEAD_BEEF;
        c_active = 0;
      end else if (!cif.req) begin
        c_active = 0;
        cif.ready = 1'b0;
        cif.rdata = $urandom;
      end else begin
        if (!c_active) begin
          c_active = 1; c_cnt = 0; c_lat = cache_lat;
        end else begin
          c_cnt++;
        end
        if (c_cnt == c_lat - 1) begin
          cif.ready = 1'b1;
          cif.rdata = mem_word(cif.addr);
          c_active = 0;
        end else begin
          cif.ready = 1'b0;
          cif.rdata = $urandom;
        end
      end

      aligned = redirect_pc & ~32'h3;
      room = !o_valid || inst_ready;
      if (redirect_valid || (o_valid && inst_ready)) o_valid = 0;
      if (!f_fetching) begin
        if (redirect_valid) f_pc = aligned;
        else if (room) f_fetching = 1;
      end else if (cif.ready) begin
        if (redirect_valid) begin
          f_pc = aligned; f_stale = 0;
        end else if (f_stale) begin
          f_pc = f_next; f_stale = 0;
        end else begin
          o_valid = 1; o_inst = cif.rdata; o_pc = f_pc;
          f_pc = f_pc + 32'd4; f_fetching = 0;
        end
      end else if (redirect_valid) begin
        f_stale = 1; f_next = aligned;
      end
    end
  end

  initial begin
    bit ok;
    bit saw;
    int k;
    cif.ready = 1'b0;
    cif.rdata = 32'h0;

    // Reset state
    #3;
    chk("rst_req", {31'b0, cif.req}, 32'd0);
    chk("rst_addr", cif.addr, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    cache_lat = 2;

    // Streaming with 2-cycle hits
    wait_fresh_req(ok);
    chk("first_addr", cif.addr, 32'h0);
    k = 0;
    for (int n = 0; n < 60 && k < 3; n++) begin
      tick();
      if (inst_valid) begin
        chk("seq_pc", inst_pc, 32'(k * 4));
        chk("seq_inst", inst, mem_word(32'(k * 4)));
        k++;
      end
    end
    chk("seq_count", 32'(k), 32'd3);
    inst_ready = 1'b0;

    // Back-pressure holds the buffer and blocks new requests
    repeat (5) begin
      tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_inst", inst, mem_word(32'h8));
      chk("bp_req", {31'b0, cif.req}, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_release_req", {31'b0, cif.req}, 32'd1);
    chk("bp_release_addr", cif.addr, 32'hC);

    // Redirect during an 8-cycle miss
    cache_lat = 8;
    wait_fresh_req(ok);
    chk("miss_addr", cif.addr, 32'h10);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    tick();
    redirect_valid = 1'b0;
    saw = 0; ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (inst_valid) saw = 1;
      if (cif.req && cif.addr == 32'h1000) begin ok = 1; break; end
      tick();
    end
    chk("miss_no_valid", {31'b0, saw}, 32'd0);
    chk("miss_new_addr", {31'b0, ok}, 32'd1);

    // Redirect coincident with ready, then two redirects in one miss
    cache_lat = 4;
    wait_fresh_req(ok);
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300; cache_lat = 8;
    tick();
    redirect_valid = 1'b0;
    chk("coinc_req", {31'b0, cif.req}, 32'd1);
    chk("coinc_addr", cif.addr, 32'h300);
    chk("coinc_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    saw = 0; ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (inst_valid) saw = 1;
      if (cif.addr == 32'h200) begin ok = 1; break; end
      tick();
    end
    chk("two_redir_no_valid", {31'b0, saw}, 32'd0);
    chk("two_redir_addr", {31'b0, ok}, 32'd1);
    cache_lat = 2;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (inst_valid) begin ok = 1; break; end
    end
    chk("two_redir_delivered", {31'b0, ok}, 32'd1);
    chk("two_redir_pc", inst_pc, 32'h200);
    chk("two_redir_inst", inst, mem_word(32'h200));
    inst_ready = 1'b0;

    // Redirect flushes a stalled buffer
    tick(); tick();
    chk("stall_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_req", {31'b0, cif.req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("flush_valid", {31'b0, inst_valid}, 32'd0);
    cache_lat = 8;
    wait_fresh_req(ok);
    chk("flush_addr", cif.addr, 32'h400);

    // Asynchronous reset mid-miss, then a late ready while idle
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, cif.req}, 32'd0);
    chk("arst_valid", {31'b0, inst_valid}, 32'd0);
    chk("arst_addr", cif.addr, 32'h0);
    repeat (2) tick();
    cache_lat = 2;
    inst_ready = 1'b1;
    rst_n = 1'b1;
    late_ready = 1'b1;
    tick();
    late_ready = 1'b0;
    chk("restart_req", {31'b0, cif.req}, 32'd1);
    chk("restart_addr", cif.addr, 32'h0);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (inst_valid) begin ok = 1; break; end
    end
    chk("restart_delivered", {31'b0, ok}, 32'd1);
    chk("restart_pc", inst_pc, 32'h0);
    chk("restart_inst", inst, mem_word(32'h0));

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      cache_lat = $urandom_range(2, 6);
    end
    redirect_valid = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
